// File: rtl/bcd_entry_to_bin_pkg.sv
// Shared definitions for the decimal operand entry block.
// - entry_state_e : entry FSM encoding, also exported on state_o for the debug digit
// - BCD_MAX       : largest legal BCD digit value
package bcd_entry_to_bin_pkg;

  typedef enum logic [1:0] {
    ENTRY_IDLE  = 2'd0,
    ENTRY_ENTRY = 2'd1,
    ENTRY_DONE  = 2'd2,
    ENTRY_ERR   = 2'd3
  } entry_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_entry_to_bin_rise_detect.sv
// Registered rising-edge detector for an already-synchronised button level.
// Ports:
// - clk_i   : clock
// - rst_i   : synchronous active-high reset (clears the history register)
// - level_i : button level, active-high
// - rise_o  : high for the single cycle in which level_i is high and was low the cycle before
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/bcd_entry_to_bin.sv
// Decimal operand entry: digits keyed MSD-first are accumulated into a binary value.
// Ports:
// - clk_i, rst_i  : clock and synchronous active-high reset
// - digit_i       : BCD digit from the switches, taken on a digit button rising edge
// - digit_btn_i   : digit button level
// - enter_btn_i   : commit button level
// - clear_btn_i   : abort/clear button level
// - value_o       : last committed binary value (changes only on commit or reset)
// - valid_o       : one-cycle pulse when value_o is updated
// - bcd_o         : packed BCD echo of the keyed digits, newest digit in [3:0]
// - ndig_o        : number of digits accepted in the current entry
// - ovf_o         : high while in the error state
// - bad_digit_o   : one-cycle pulse when a non-BCD digit is rejected
// - state_o       : entry FSM state for the debug display
module bcd_entry_to_bin
  import bcd_entry_to_bin_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int OUT_WIDTH  = 8,
  parameter int MAX_VALUE  = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [3:0]              digit_i,
  input  logic                    digit_btn_i,
  input  logic                    enter_btn_i,
  input  logic                    clear_btn_i,
  output logic [OUT_WIDTH-1:0]    value_o,
  output logic                    valid_o,
  output logic [4*MAX_DIGITS-1:0] bcd_o,
  output logic [1:0]              ndig_o,
  output logic                    ovf_o,
  output logic                    bad_digit_o,
  output logic [1:0]              state_o
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int NW = OUT_WIDTH + 4;

  logic dig_ev, ent_ev, clr_ev;

  rise_detect u_rise_digit (.clk_i(clk_i), .rst_i(rst_i), .level_i(digit_btn_i), .rise_o(dig_ev));
  rise_detect u_rise_enter (.clk_i(clk_i), .rst_i(rst_i), .level_i(enter_btn_i), .rise_o(ent_ev));
  rise_detect u_rise_clear (.clk_i(clk_i), .rst_i(rst_i), .level_i(clear_btn_i), .rise_o(clr_ev));

  entry_state_e         state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] value_q, value_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [1:0]           ndig_q, ndig_d;
  logic                 valid_q, valid_d;
  logic                 bad_q, bad_d;

  // acc*10 + digit as shift-and-add, widened so an out-of-range result is visible
  logic [NW-1:0] acc_ext;
  logic [NW-1:0] nxt;

  assign acc_ext = {4'b0000, acc_q};
  assign nxt     = (acc_ext << 3) + (acc_ext << 1) + {{OUT_WIDTH{1'b0}}, digit_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ENTRY_IDLE;
      acc_q   <= '0;
      value_q <= '0;
      bcd_q   <= '0;
      ndig_q  <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  // Clear beats enter beats digit; a lower-priority event in the same cycle is dropped.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    value_d = value_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    valid_d = 1'b0;
    bad_d   = 1'b0;
    if (clr_ev) begin
      // value_q is deliberately kept so downstream still sees the last operand
      state_d = ENTRY_IDLE;
      acc_d   = '0;
      bcd_d   = '0;
      ndig_d  = '0;
    end else if (ent_ev) begin
      if (state_q == ENTRY_ENTRY) begin
        state_d = ENTRY_DONE;
        value_d = acc_q;
        valid_d = 1'b1;
      end
    end else if (dig_ev) begin
      if (digit_i > BCD_MAX) begin
        bad_d = 1'b1;
      end else begin
        case (state_q)
          ENTRY_IDLE, ENTRY_DONE: begin
            state_d = ENTRY_ENTRY;
            acc_d   = {{(OUT_WIDTH-4){1'b0}}, digit_i};
            bcd_d   = {{(BW-4){1'b0}}, digit_i};
            ndig_d  = 2'd1;
          end
          ENTRY_ENTRY: begin
            // a full entry silently ignores further digits
            if (ndig_q < 2'(MAX_DIGITS)) begin
              if (nxt > NW'(MAX_VALUE)) begin
                state_d = ENTRY_ERR;
              end else begin
                acc_d  = nxt[OUT_WIDTH-1:0];
                bcd_d  = {bcd_q[BW-5:0], digit_i};
                ndig_d = ndig_q + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign value_o     = value_q;
  assign valid_o     = valid_q;
  assign bcd_o       = bcd_q;
  assign ndig_o      = ndig_q;
  assign ovf_o       = (state_q == ENTRY_ERR);
  assign bad_digit_o = bad_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
module tb_bcd_entry_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] digit = 4'd0;
  logic dbtn = 1'b0, ebtn = 1'b0, cbtn = 1'b0;

  logic [7:0]  v8;
  logic        val8, ovf8, bad8;
  logic [11:0] bcd8;
  logic [1:0]  nd8, st8;

  logic [9:0]  v10;
  logic        val10, ovf10, bad10;
  logic [11:0] bcd10;
  logic [1:0]  nd10, st10;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_entry_to_bin u_dut (
    .clk_i(clk), .rst_i(rst), .digit_i(digit), .digit_btn_i(dbtn),
    .enter_btn_i(ebtn), .clear_btn_i(cbtn), .value_o(v8), .valid_o(val8),
    .bcd_o(bcd8), .ndig_o(nd8), .ovf_o(ovf8), .bad_digit_o(bad8), .state_o(st8)
  );

  bcd_entry_to_bin #(.MAX_DIGITS(3), .OUT_WIDTH(10), .MAX_VALUE(1023)) u_dut10 (
    .clk_i(clk), .rst_i(rst), .digit_i(digit), .digit_btn_i(dbtn),
    .enter_btn_i(ebtn), .clear_btn_i(cbtn), .value_o(v10), .valid_o(val10),
    .bcd_o(bcd10), .ndig_o(nd10), .ovf_o(ovf10), .bad_digit_o(bad10), .state_o(st10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    dbtn  = 1'b1;
    tick();
    dbtn  = 1'b0;
    tick();
    $display("key %0d: bcd=%03h ndig=%0d state=%0d", d, bcd8, nd8, st8);
  endtask

  task automatic press_clear();
    cbtn = 1'b1;
    tick();
    cbtn = 1'b0;
    tick();
    $display("clear: state=%0d", st8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    key(4'd1);
    key(4'd2);
    checks++; if (nd8 !== 2'd2) begin errors++; $display("FAIL pre_reset_ndig got %0d want 2", nd8); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-entry");
    checks++; if (v8 !== 8'd0 || val8 !== 1'b0 || bcd8 !== 12'h000) begin errors++; $display("FAIL reset_outputs got v=%0d valid=%0b bcd=%03h want 0 0 000", v8, val8, bcd8); end
    checks++; if (nd8 !== 2'd0 || ovf8 !== 1'b0 || bad8 !== 1'b0 || st8 !== 2'd0) begin errors++; $display("FAIL reset_state got ndig=%0d ovf=%0b bad=%0b st=%0d want 0 0 0 0", nd8, ovf8, bad8, st8); end
    // acc must be cleared: a fresh entry of 5 then enter commits exactly 5
    key(4'd5);
    ebtn = 1'b1; tick(); ebtn = 1'b0; tick();
    checks++; if (v8 !== 8'd5) begin errors++; $display("FAIL reset_acc got %0d want 5", v8); end
  endtask

  task automatic test_commit();
    key(4'd1);
    checks++; if (bcd8 !== 12'h001 || nd8 !== 2'd1 || st8 !== 2'd1) begin errors++; $display("FAIL commit_d1 got bcd=%03h nd=%0d st=%0d want 001 1 1", bcd8, nd8, st8); end
    key(4'd2);
    checks++; if (bcd8 !== 12'h012 || nd8 !== 2'd2) begin errors++; $display("FAIL commit_d2 got bcd=%03h nd=%0d want 012 2", bcd8, nd8); end
    key(4'd8);
    checks++; if (bcd8 !== 12'h128 || nd8 !== 2'd3 || v8 !== 8'd5) begin errors++; $display("FAIL commit_d3 got bcd=%03h nd=%0d v=%0d want 128 3 5", bcd8, nd8, v8); end
    ebtn = 1'b1;
    tick();
    $display("enter: value=%0d valid=%0b", v8, val8);
    checks++; if (v8 !== 8'd128 || val8 !== 1'b1 || st8 !== 2'd2) begin errors++; $display("FAIL commit_enter got v=%0d valid=%0b st=%0d want 128 1 2", v8, val8, st8); end
    tick();
    checks++; if (val8 !== 1'b0) begin errors++; $display("FAIL commit_valid_width got %0b want 0", val8); end
    ebtn = 1'b0;
    tick();
    checks++; if (bcd8 !== 12'h128 || v8 !== 8'd128) begin errors++; $display("FAIL commit_hold got bcd=%03h v=%0d want 128 128", bcd8, v8); end
  endtask

  task automatic test_overflow();
    // exactly MAX_VALUE is legal
    key(4'd2); key(4'd5); key(4'd5);
    checks++; if (st8 !== 2'd1 || ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_255 got st=%0d ovf=%0b want 1 0", st8, ovf8); end
    ebtn = 1'b1; tick(); ebtn = 1'b0; tick();
    checks++; if (v8 !== 8'd255) begin errors++; $display("FAIL ovf_255_value got %0d want 255", v8); end
    key(4'd2);
    checks++; if (bcd8 !== 12'h002 || nd8 !== 2'd1) begin errors++; $display("FAIL ovf_restart got bcd=%03h nd=%0d want 002 1", bcd8, nd8); end
    key(4'd5); key(4'd6);
    checks++; if (st8 !== 2'd3 || ovf8 !== 1'b1 || v8 !== 8'd255) begin errors++; $display("FAIL ovf_err got st=%0d ovf=%0b v=%0d want 3 1 255", st8, ovf8, v8); end
    checks++; if (bcd8 !== 12'h025 || nd8 !== 2'd2) begin errors++; $display("FAIL ovf_keep got bcd=%03h nd=%0d want 025 2", bcd8, nd8); end
    ebtn = 1'b1;
    tick();
    checks++; if (val8 !== 1'b0 || st8 !== 2'd3 || v8 !== 8'd255) begin errors++; $display("FAIL ovf_enter got valid=%0b st=%0d v=%0d want 0 3 255", val8, st8, v8); end
    ebtn = 1'b0;
    tick();
    press_clear();
    checks++; if (st8 !== 2'd0 || ovf8 !== 1'b0 || bcd8 !== 12'h000 || nd8 !== 2'd0 || v8 !== 8'd255) begin errors++; $display("FAIL ovf_clear got st=%0d ovf=%0b bcd=%03h nd=%0d v=%0d want 0 0 000 0 255", st8, ovf8, bcd8, nd8, v8); end
  endtask

  task automatic test_bad_digit();
    key(4'd3);
    digit = 4'hC;
    dbtn  = 1'b1;
    tick();
    $display("bad digit C: bad=%0b ndig=%0d", bad8, nd8);
    checks++; if (bad8 !== 1'b1 || nd8 !== 2'd1 || bcd8 !== 12'h003 || st8 !== 2'd1) begin errors++; $display("FAIL bad_pulse got bad=%0b nd=%0d bcd=%03h st=%0d want 1 1 003 1", bad8, nd8, bcd8, st8); end
    tick();
    checks++; if (bad8 !== 1'b0) begin errors++; $display("FAIL bad_width got %0b want 0", bad8); end
    dbtn = 1'b0;
    tick();
    digit = 4'd4;
    dbtn  = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    dbtn = 1'b0;
    tick();
    $display("held digit 4: bcd=%03h ndig=%0d", bcd8, nd8);
    checks++; if (nd8 !== 2'd2 || bcd8 !== 12'h034) begin errors++; $display("FAIL held_once got nd=%0d bcd=%03h want 2 034", nd8, bcd8); end
    press_clear();
  endtask

  task automatic test_max_digits();
    key(4'd9); key(4'd9);
    checks++; if (st8 !== 2'd1 || bcd8 !== 12'h099) begin errors++; $display("FAIL max_99 got st=%0d bcd=%03h want 1 099", st8, bcd8); end
    key(4'd9);
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL max_999_ovf8 got %0b want 1", ovf8); end
    key(4'd9);
    checks++; if (nd10 !== 2'd3 || bcd10 !== 12'h999 || st10 !== 2'd1 || ovf10 !== 1'b0) begin errors++; $display("FAIL max_4th got nd=%0d bcd=%03h st=%0d ovf=%0b want 3 999 1 0", nd10, bcd10, st10, ovf10); end
    ebtn = 1'b1;
    tick();
    $display("enter wide: value=%0d valid=%0b", v10, val10);
    checks++; if (v10 !== 10'd999 || val10 !== 1'b1) begin errors++; $display("FAIL max_value got v=%0d valid=%0b want 999 1", v10, val10); end
    ebtn = 1'b0;
    tick();
    press_clear();
  endtask

  task automatic test_back_to_back();
    key(4'd7);
    digit = 4'd5;
    dbtn  = 1'b1;
    ebtn  = 1'b1;
    tick();
    $display("enter+digit: value=%0d valid=%0b", v8, val8);
    checks++; if (v8 !== 8'd7 || val8 !== 1'b1 || st8 !== 2'd2) begin errors++; $display("FAIL b2b_enter got v=%0d valid=%0b st=%0d want 7 1 2", v8, val8, st8); end
    checks++; if (nd8 !== 2'd1 || bcd8 !== 12'h007) begin errors++; $display("FAIL b2b_drop got nd=%0d bcd=%03h want 1 007", nd8, bcd8); end
    dbtn = 1'b0;
    ebtn = 1'b0;
    tick();
    key(4'd3);
    cbtn = 1'b1;
    ebtn = 1'b1;
    tick();
    $display("clear+enter: state=%0d valid=%0b", st8, val8);
    checks++; if (st8 !== 2'd0 || val8 !== 1'b0 || v8 !== 8'd7 || nd8 !== 2'd0) begin errors++; $display("FAIL b2b_clear got st=%0d valid=%0b v=%0d nd=%0d want 0 0 7 0", st8, val8, v8, nd8); end
    cbtn = 1'b0;
    ebtn = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_bad_digit();
    test_max_digits();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
